// File: rtl/rep_sequencer.sv
// REP string-instruction sequencer: expands one REP instruction into per-element
// iterations with pointer/count updates, then pulses done with writeback values.
module rep_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        start_ready,
    input  logic [31:0] ecx_in,
    input  logic [31:0] esi_in,
    input  logic [31:0] edi_in,
    input  logic [1:0]  size,
    input  logic        df,
    input  logic        stall,
    input  logic        flush,
    output logic        iter_valid,
    output logic [31:0] iter_esi,
    output logic [31:0] iter_edi,
    output logic [31:0] iter_ecx,
    output logic        iter_last,
    output logic        done,
    output logic [31:0] ecx_out,
    output logic [31:0] esi_out,
    output logic [31:0] edi_out,
    output logic        busy,
    output logic [1:0]  o_dbg_state
);

    // Handshake: an iteration transfers on a rising edge where iter_valid=1 and
    // stall=0; flush or rst in that cycle cancels the transfer.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_ecx;
    logic [31:0] r_esi;
    logic [31:0] r_edi;
    logic [1:0]  r_size;
    logic        r_df;

    logic [31:0] w_ecx_nxt;
    logic [31:0] w_esi_nxt;
    logic [31:0] w_edi_nxt;
    logic [1:0]  w_size_nxt;
    logic        w_df_nxt;
    logic [31:0] w_mag;
    logic [31:0] w_delta;

    // Element size in bytes, negated when walking downwards.
    always_comb begin
        w_mag   = 32'd1 << r_size;
        w_delta = r_df ? (~w_mag + 32'd1) : w_mag;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ecx_nxt   = r_ecx;
        w_esi_nxt   = r_esi;
        w_edi_nxt   = r_edi;
        w_size_nxt  = r_size;
        w_df_nxt    = r_df;
        if (flush) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_ecx_nxt   = ecx_in;
                        w_esi_nxt   = esi_in;
                        w_edi_nxt   = edi_in;
                        w_size_nxt  = size;
                        w_df_nxt    = df;
                        w_state_nxt = (ecx_in == 32'd0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (!stall) begin
                        w_ecx_nxt = r_ecx - 32'd1;
                        w_esi_nxt = r_esi + w_delta;
                        w_edi_nxt = r_edi + w_delta;
                        if (r_ecx == 32'd1) begin
                            w_state_nxt = S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    w_state_nxt = S_IDLE;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ecx   <= 32'd0;
            r_esi   <= 32'd0;
            r_edi   <= 32'd0;
            r_size  <= 2'd0;
            r_df    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ecx   <= w_ecx_nxt;
            r_esi   <= w_esi_nxt;
            r_edi   <= w_edi_nxt;
            r_size  <= w_size_nxt;
            r_df    <= w_df_nxt;
        end
    end

    // Data outputs come straight from the registers, so they hold when unqualified.
    assign start_ready = (r_state == S_IDLE);
    assign busy        = (r_state != S_IDLE);
    assign iter_valid  = (r_state == S_RUN);
    assign iter_last   = (r_state == S_RUN) && (r_ecx == 32'd1);
    assign done        = (r_state == S_DONE);
    assign iter_ecx    = r_ecx;
    assign iter_esi    = r_esi;
    assign iter_edi    = r_edi;
    assign ecx_out     = r_ecx;
    assign esi_out     = r_esi;
    assign edi_out     = r_edi;
    assign o_dbg_state = r_state;

endmodule
